// File: rtl/uart_dec_sender.sv
// Converts an 8-bit value to decimal ASCII with a sequential double-dabble
// and feeds the characters, optionally CR/LF terminated, to a UART transmitter.
module uart_dec_sender #(
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter bit APPEND_CRLF    = 1'b1
) (
  input  logic       clk_50m,
  input  logic       clear,
  input  logic [7:0] value,
  input  logic       send,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_LOAD,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t      r_state, w_state_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [11:0] r_bcd, w_bcd_n, w_bcd_adj;
  logic [2:0]  r_cnt, w_cnt_n;
  logic        r_conv_done, w_conv_done_n;
  logic [7:0]  r_chars [5];
  logic [7:0]  w_chars_n [5];
  logic [7:0]  w_list [5];
  logic [2:0]  w_nlist;
  logic [2:0]  r_nchars, w_nchars_n;
  logic [2:0]  r_idx, w_idx_n;
  logic [7:0]  r_tx_data, w_tx_data_n;
  logic        r_tx_en, w_tx_en_n;
  logic        r_busy, w_busy_n;
  logic        r_done, w_done_n;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned n = 0; n < 3; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5)
        w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    end
  end

  // Character list is packed from slot 0 upward; suppressed digits simply do not claim a slot.
  always_comb begin
    w_list  = '{default: 8'h00};
    w_nlist = 3'd0;
    if (!SUPPRESS_ZEROS || (r_bcd[11:8] != 4'd0)) begin
      w_list[w_nlist] = {4'h3, r_bcd[11:8]};
      w_nlist         = w_nlist + 3'd1;
    end
    if (!SUPPRESS_ZEROS || (r_bcd[11:4] != 8'd0)) begin
      w_list[w_nlist] = {4'h3, r_bcd[7:4]};
      w_nlist         = w_nlist + 3'd1;
    end
    w_list[w_nlist] = {4'h3, r_bcd[3:0]};
    w_nlist         = w_nlist + 3'd1;
    if (APPEND_CRLF) begin
      w_list[w_nlist] = 8'h0D;
      w_nlist         = w_nlist + 3'd1;
      w_list[w_nlist] = 8'h0A;
      w_nlist         = w_nlist + 3'd1;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_shift_n     = r_shift;
    w_bcd_n       = r_bcd;
    w_cnt_n       = r_cnt;
    w_conv_done_n = r_conv_done;
    w_chars_n     = r_chars;
    w_nchars_n    = r_nchars;
    w_idx_n       = r_idx;
    w_tx_data_n   = r_tx_data;
    w_tx_en_n     = r_tx_en;
    w_busy_n      = r_busy;
    w_done_n      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (send) begin
          w_shift_n     = value;
          w_bcd_n       = '0;
          w_cnt_n       = '0;
          w_conv_done_n = 1'b0;
          w_busy_n      = 1'b1;
          w_state_n     = S_CONV;
        end
      end
      // Eight shift cycles, then one more CONV cycle to latch the finished list.
      S_CONV: begin
        if (!r_conv_done) begin
          w_bcd_n       = {w_bcd_adj[10:0], r_shift[7]};
          w_shift_n     = {r_shift[6:0], 1'b0};
          w_cnt_n       = r_cnt + 3'd1;
          w_conv_done_n = (r_cnt == 3'd7);
        end else begin
          w_chars_n   = w_list;
          w_nchars_n  = w_nlist;
          w_idx_n     = '0;
          w_tx_data_n = w_list[0];
          w_state_n   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_tx_data_n = r_chars[r_idx];
        if (!tx_busy) begin
          w_tx_en_n = 1'b1;
          w_state_n = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          w_tx_en_n = 1'b0;
          w_state_n = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_idx == (r_nchars - 3'd1)) begin
            w_state_n = S_DONE;
          end else begin
            w_idx_n   = r_idx + 3'd1;
            w_state_n = S_LOAD;
          end
        end
      end
      S_DONE: begin
        w_done_n  = 1'b1;
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_conv_done <= 1'b0;
      r_chars     <= '{default: 8'h00};
      r_nchars    <= '0;
      r_idx       <= '0;
      r_tx_data   <= '0;
      r_tx_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_shift     <= w_shift_n;
      r_bcd       <= w_bcd_n;
      r_cnt       <= w_cnt_n;
      r_conv_done <= w_conv_done_n;
      r_chars     <= w_chars_n;
      r_nchars    <= w_nchars_n;
      r_idx       <= w_idx_n;
      r_tx_data   <= w_tx_data_n;
      r_tx_en     <= w_tx_en_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
    end
  end

  assign tx_data = r_tx_data;
  assign tx_en   = r_tx_en;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_uart_dec_sender.sv
// Bench for uart_dec_sender: two instances (default and raw-digit parameters),
// each driving a behavioural transmitter stub, checked against a decimal text model.
module tb_uart_dec_sender;

  logic       clk_50m = 1'b0;
  logic       clear   = 1'b1;
  logic [7:0] value    [2] = '{8'd0, 8'd0};
  logic       send     [2] = '{1'b0, 1'b0};
  logic       pre_busy [2] = '{1'b0, 1'b0};
  int         ack_delay[2] = '{0, 0};
  int         frame    [2] = '{20, 20};
  logic       tx_busy  [2];
  logic [7:0] tx_data  [2];
  logic       tx_en    [2];
  logic       busy     [2];
  logic       done     [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #10 clk_50m = ~clk_50m;

  uart_dec_sender dut (
    .clk_50m(clk_50m), .clear(clear), .value(value[0]), .send(send[0]),
    .tx_busy(tx_busy[0]), .tx_data(tx_data[0]), .tx_en(tx_en[0]),
    .busy(busy[0]), .done(done[0])
  );

  uart_dec_sender #(.SUPPRESS_ZEROS(1'b0), .APPEND_CRLF(1'b0)) dut_raw (
    .clk_50m(clk_50m), .clear(clear), .value(value[1]), .send(send[1]),
    .tx_busy(tx_busy[1]), .tx_data(tx_data[1]), .tx_en(tx_en[1]),
    .busy(busy[1]), .done(done[1])
  );

  // Transmitter stub: latches a byte when tx_en is seen idle, asserts busy after
  // ack_delay cycles for frame cycles. Not affected by clear, like the real one.
  for (genvar c = 0; c < 2; c++) begin : g_stub
    int         phase = 0;
    int         cnt   = 0;
    int         viol  = 0;
    logic       r_busy  = 1'b0;
    logic       prev_en = 1'b0;
    logic       prev_bz = 1'b0;
    logic [7:0] cap     = 8'h00;
    logic [7:0] capq[$];

    always @(posedge clk_50m) begin
      prev_en <= tx_en[c];
      prev_bz <= tx_busy[c];
      if ((tx_en[c] && !prev_en && prev_bz) ||
          (phase == 1 && (!tx_en[c] || tx_data[c] !== cap)) ||
          (phase == 2 && tx_en[c] && tx_data[c] !== cap))
        viol <= viol + 1;
      case (phase)
        0: if (tx_en[c] === 1'b1) begin
             cap <= tx_data[c];
             capq.push_back(tx_data[c]);
             if (ack_delay[c] == 0) begin
               r_busy <= 1'b1; cnt <= frame[c]; phase <= 2;
             end else begin
               cnt <= ack_delay[c]; phase <= 1;
             end
           end
        1: if (cnt <= 1) begin
             r_busy <= 1'b1; cnt <= frame[c]; phase <= 2;
           end else cnt <= cnt - 1;
        default: if (cnt <= 1) begin
             r_busy <= 1'b0; phase <= 0;
           end else cnt <= cnt - 1;
      endcase
    end
  end

  assign tx_busy[0] = g_stub[0].r_busy | pre_busy[0];
  assign tx_busy[1] = g_stub[1].r_busy | pre_busy[1];

  function automatic int qsize(input int ch);
    return (ch == 0) ? g_stub[0].capq.size() : g_stub[1].capq.size();
  endfunction

  function automatic int viol_of(input int ch);
    return (ch == 0) ? g_stub[0].viol : g_stub[1].viol;
  endfunction

  task automatic snap(input int ch, input int start);
    got_q.delete();
    for (int i = start; i < qsize(ch); i++)
      got_q.push_back((ch == 0) ? g_stub[0].capq[i] : g_stub[1].capq[i]);
  endtask

  // Reference text: decimal digits of v, leading zeros dropped on channel 0,
  // CR/LF only on channel 0.
  task automatic build_expected(input int ch, input int v);
    int h, t, u;
    bit sup;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    sup = (ch == 0);
    exp_q.delete();
    if (!sup || h != 0) exp_q.push_back(8'(48 + h));
    if (!sup || h != 0 || t != 0) exp_q.push_back(8'(48 + t));
    exp_q.push_back(8'(48 + u));
    if (ch == 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  function automatic logic [47:0] pack_q(input logic [7:0] q[$]);
    logic [47:0] r;
    r = '0;
    r[47:40] = 8'(q.size());
    for (int i = 0; i < 5; i++)
      if (i < q.size()) r[39-8*i -: 8] = q[i];
    return r;
  endfunction

  // One message: n counts negedges after the accepting edge (n=1 is the first).
  task automatic send_and_wait(input int ch, input logic [7:0] v, input int mid_send_at,
                               input int release_at, output int n_done, output int first_en,
                               output int busy_low);
    int n, start;
    start = qsize(ch);
    @(negedge clk_50m);
    value[ch] = v; send[ch] = 1'b1;
    @(negedge clk_50m);
    send[ch] = 1'b0; value[ch] = 8'($urandom);
    n = 1; n_done = 0; first_en = -1; busy_low = 0;
    while (n_done == 0 && n < 4000) begin
      if (!busy[ch] && !done[ch]) busy_low++;
      if (tx_en[ch] && first_en < 0) first_en = n;
      if (done[ch]) n_done++;
      if (n == mid_send_at) begin send[ch] = 1'b1; value[ch] = 8'd99; end
      else send[ch] = 1'b0;
      if (n == release_at) pre_busy[ch] = 1'b0;
      @(negedge clk_50m); n++;
    end
    send[ch] = 1'b0;
    repeat (3) begin
      if (done[ch]) n_done++;
      @(negedge clk_50m);
    end
    snap(ch, start);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_50m);
    for (int c = 0; c < 2; c++) begin
      checks++; if (tx_data[c] !== 8'h00) begin errors++; $display("FAIL reset_tx_data[%0d]: got %h expected 00", c, tx_data[c]); end
      checks++; if (tx_en[c] !== 1'b0) begin errors++; $display("FAIL reset_tx_en[%0d]: got %b expected 0", c, tx_en[c]); end
      checks++; if (busy[c] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", c, busy[c]); end
      checks++; if (done[c] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", c, done[c]); end
    end
    clear = 1'b0;
    repeat (2) @(negedge clk_50m);
  endtask

  task automatic test_basic;
    int nd, fe, bl, v0;
    v0 = viol_of(0);
    ack_delay[0] = 0; frame[0] = 20;
    send_and_wait(0, 8'd123, -1, -1, nd, fe, bl);
    build_expected(0, 123);
    checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL basic_seq: got %h expected %h", pack_q(got_q), pack_q(exp_q)); end
    checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
    checks++; if (fe != 11) begin errors++; $display("FAIL basic_first_tx_en_cycle: got %0d expected 11", fe); end
    checks++; if (bl != 0) begin errors++; $display("FAIL basic_busy_gap: got %0d low cycles expected 0", bl); end
    checks++; if (viol_of(0) != v0) begin errors++; $display("FAIL basic_handshake: got %0d violations expected 0", viol_of(0) - v0); end
  endtask

  task automatic test_small_values;
    int nd, fe, bl;
    int vals[2] = '{7, 0};
    foreach (vals[i]) begin
      send_and_wait(0, 8'(vals[i]), -1, -1, nd, fe, bl);
      build_expected(0, vals[i]);
      checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL small_seq(%0d): got %h expected %h", vals[i], pack_q(got_q), pack_q(exp_q)); end
      checks++; if (nd != 1) begin errors++; $display("FAIL small_done(%0d): got %0d expected 1", vals[i], nd); end
    end
  endtask

  task automatic test_raw_digits;
    int nd, fe, bl;
    int vals[2] = '{5, 255};
    ack_delay[1] = 0; frame[1] = 20;
    foreach (vals[i]) begin
      send_and_wait(1, 8'(vals[i]), -1, -1, nd, fe, bl);
      build_expected(1, vals[i]);
      checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL raw_seq(%0d): got %h expected %h", vals[i], pack_q(got_q), pack_q(exp_q)); end
      checks++; if (nd != 1) begin errors++; $display("FAIL raw_done(%0d): got %0d expected 1", vals[i], nd); end
    end
  endtask

  task automatic test_prebusy;
    int nd, fe, bl, v0;
    v0 = viol_of(0);
    ack_delay[0] = 4; frame[0] = 15;
    pre_busy[0] = 1'b1;
    repeat (50) @(negedge clk_50m);
    send_and_wait(0, 8'd208, -1, 30, nd, fe, bl);
    build_expected(0, 208);
    checks++; if (fe != 31) begin errors++; $display("FAIL prebusy_first_tx_en: got cycle %0d expected 31", fe); end
    checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL prebusy_seq: got %h expected %h", pack_q(got_q), pack_q(exp_q)); end
    checks++; if (viol_of(0) != v0) begin errors++; $display("FAIL prebusy_handshake: got %0d violations expected 0", viol_of(0) - v0); end
    checks++; if (nd != 1) begin errors++; $display("FAIL prebusy_done: got %0d expected 1", nd); end
    pre_busy[0] = 1'b0; ack_delay[0] = 0; frame[0] = 20;
  endtask

  task automatic test_ignore_send;
    int nd, fe, bl;
    send_and_wait(0, 8'd150, 40, -1, nd, fe, bl);
    build_expected(0, 150);
    checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL ignore_seq: got %h expected %h", pack_q(got_q), pack_q(exp_q)); end
    checks++; if (bl != 0) begin errors++; $display("FAIL ignore_busy_gap: got %0d low cycles expected 0", bl); end
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done: got %0d expected 1", nd); end
  endtask

  task automatic test_clear;
    int nd, fe, bl, start, n;
    start = qsize(0);
    @(negedge clk_50m);
    value[0] = 8'd200; send[0] = 1'b1;
    @(negedge clk_50m);
    send[0] = 1'b0;
    n = 0;
    while (qsize(0) - start < 2 && n < 2000) begin @(negedge clk_50m); n++; end
    checks++; if (qsize(0) - start < 2) begin errors++; $display("FAIL clear_reach_second_char: got %0d chars expected 2", qsize(0) - start); end
    #5 clear = 1'b1;
    #1;
    checks++; if (tx_en[0] !== 1'b0) begin errors++; $display("FAIL clear_tx_en: got %b expected 0", tx_en[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b expected 0", busy[0]); end
    checks++; if (tx_data[0] !== 8'h00) begin errors++; $display("FAIL clear_tx_data: got %h expected 00", tx_data[0]); end
    @(negedge clk_50m);
    clear = 1'b0;
    send_and_wait(0, 8'd42, -1, -1, nd, fe, bl);
    build_expected(0, 42);
    checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL clear_resend_seq: got %h expected %h", pack_q(got_q), pack_q(exp_q)); end
    checks++; if (nd != 1) begin errors++; $display("FAIL clear_resend_done: got %0d expected 1", nd); end
  endtask

  task automatic test_back_to_back;
    int start, n;
    logic [7:0] a, b;
    a = 8'($urandom_range(100, 255)); b = 8'($urandom_range(0, 99));
    start = qsize(0);
    @(negedge clk_50m);
    value[0] = a; send[0] = 1'b1;
    n = 0;
    do begin @(negedge clk_50m); n++; end while (!done[0] && n < 4000);
    snap(0, start);
    build_expected(0, a);
    checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL b2b_first_seq: got %h expected %h", pack_q(got_q), pack_q(exp_q)); end
    value[0] = b;
    start = qsize(0);
    @(negedge clk_50m);
    checks++; if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin errors++; $display("FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0", busy[0], done[0]); end
    send[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 4000) begin @(negedge clk_50m); n++; end
    snap(0, start);
    build_expected(0, b);
    checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL b2b_second_seq: got %h expected %h", pack_q(got_q), pack_q(exp_q)); end
    repeat (2) @(negedge clk_50m);
  endtask

  task automatic test_random;
    int nd, fe, bl, ch, v;
    for (int i = 0; i < 12; i++) begin
      ch = i % 2;
      v = $urandom_range(0, 255);
      ack_delay[ch] = $urandom_range(0, 3);
      frame[ch] = $urandom_range(1, 25);
      send_and_wait(ch, 8'(v), -1, -1, nd, fe, bl);
      build_expected(ch, v);
      checks++; if (pack_q(got_q) !== pack_q(exp_q)) begin errors++; $display("FAIL random_seq(ch%0d,%0d): got %h expected %h", ch, v, pack_q(got_q), pack_q(exp_q)); end
      checks++; if (nd != 1) begin errors++; $display("FAIL random_done(ch%0d,%0d): got %0d expected 1", ch, v, nd); end
    end
    for (int c = 0; c < 2; c++) begin
      checks++; if (viol_of(c) != 0) begin errors++; $display("FAIL random_handshake[%0d]: got %0d violations expected 0", c, viol_of(c)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_values();
    test_raw_digits();
    test_prebusy();
    test_ignore_send();
    test_clear();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
